// File: rtl/shift_left_logical_seq_32bit.sv
// Multi-cycle 32-bit logical left shifter: one shift-amount bit per clock (1,2,4,8,16), start/done handshake.
// Optional macro SLL_EARLY_EXIT_EN ends the operation once no higher shift-amount bits remain (or out-of-range).
module shift_left_logical_seq_32bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] X,
   input  logic [31:0] Y,
   output logic        busy,
   output logic        done,
   output logic [31:0] Z
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] acc;
   logic [31:0] stage_val;
   logic [4:0]  amt;
   logic [2:0]  k;
   logic        oor;
   logic        last_stage;
   logic        accept;

   assign busy   = (state == SHIFT);
   assign done   = (state == DONE);
   assign accept = start && (state != SHIFT);

   always_comb begin
      stage_val = acc;
      case (k)
         3'd0: if (amt[0]) stage_val = {acc[30:0], 1'b0};
         3'd1: if (amt[1]) stage_val = {acc[29:0], 2'b0};
         3'd2: if (amt[2]) stage_val = {acc[27:0], 4'b0};
         3'd3: if (amt[3]) stage_val = {acc[23:0], 8'b0};
         3'd4: if (amt[4]) stage_val = {acc[15:0], 16'b0};
         default: stage_val = acc;
      endcase
   end

`ifdef SLL_EARLY_EXIT_EN
   // Finish as soon as every remaining higher amount bit is zero.
   assign last_stage = (k == 3'd4) || oor || (((amt >> k) >> 1) == 5'd0);
`else
   assign last_stage = (k == 3'd4);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_stage) state_nxt = DONE;
         DONE:    state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= 32'd0;
         amt <= 5'd0;
         k   <= 3'd0;
         oor <= 1'b0;
         Z   <= 32'd0;
      end else if (accept) begin
         acc <= X;
         amt <= Y[4:0];
         oor <= |Y[31:5];
         k   <= 3'd0;
      end else if (state == SHIFT) begin
         acc <= stage_val;
         if (last_stage) Z <= oor ? 32'd0 : stage_val;
         else            k <= k + 3'd1;
      end
   end

endmodule
